// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus per-bit tick-sampled debounce filter for the board slide switches.
// Reports updates as a one-cycle pulse and as a sticky flag cleared by ack.
module switch_debouncer #(
    parameter int WIDTH        = 16,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_switches,
    input  logic             ack,
    output logic [WIDTH-1:0] switches,
    output logic             change_pulse,
    output logic             changed
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;
    logic [PW-1:0]    presc_reg;
    logic [PW-1:0]    presc_next;
    logic             tick;
    logic [WIDTH-1:0] bit_update;
    logic             change_pulse_reg;
    logic             changed_reg;
    logic             changed_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= raw_switches;
            sync2_reg <= sync1_reg;
        end
    end

    // With TICK_DIV of 1 the counter sits at 0 and tick is permanently high.
    assign tick = (presc_reg == PRESC_LAST);

    always_comb begin
        presc_next = presc_reg + 1'b1;
        if (tick) begin
            presc_next = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] cnt_next;
            logic          sw_reg;
            logic          upd;

            // Any agreeing tick restarts the run; the STABLE_TICKS-th differing tick commits.
            always_comb begin
                cnt_next = cnt_reg;
                upd      = 1'b0;
                if (tick) begin
                    if (sync2_reg[gi] == sw_reg) begin
                        cnt_next = '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        cnt_next = '0;
                        upd      = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    cnt_reg <= '0;
                    sw_reg  <= 1'b0;
                end else begin
                    cnt_reg <= cnt_next;
                    if (upd) begin
                        sw_reg <= sync2_reg[gi];
                    end
                end
            end

            assign bit_update[gi] = upd;
            assign switches[gi]   = sw_reg;
        end
    endgenerate

    always_comb begin
        changed_next = changed_reg;
        if (|bit_update) begin
            changed_next = 1'b1;
        end else if (ack) begin
            changed_next = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            change_pulse_reg <= 1'b0;
            changed_reg      <= 1'b0;
        end else begin
            change_pulse_reg <= |bit_update;
            changed_reg      <= changed_next;
        end
    end

    assign change_pulse = change_pulse_reg;
    assign changed      = changed_reg;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer: TICK_DIV=4/STABLE_TICKS=3 instance plus a 1/1 instance.
// Edge n counts rising edges since reset release; filter ticks commit on edges 4, 8, 12, ...
module tb_switch_debouncer;

    logic        clock = 1'b0;
    logic        reset_a;
    logic [15:0] raw_a;
    logic        ack_a;
    logic [15:0] switches_a;
    logic        pulse_a;
    logic        changed_a;

    logic        reset_b;
    logic [15:0] raw_b;
    logic        ack_b;
    logic [15:0] switches_b;
    logic        pulse_b;
    logic        changed_b;

    int n_vec = 0;
    int n_err = 0;
    int edge_n = 0;
    int pulse_cnt_a = 0;
    int pulse_mark;

    always #5 clock = ~clock;

    switch_debouncer #(.WIDTH(16), .TICK_DIV(4), .STABLE_TICKS(3)) dut_a (
        .clock        (clock),
        .reset        (reset_a),
        .raw_switches (raw_a),
        .ack          (ack_a),
        .switches     (switches_a),
        .change_pulse (pulse_a),
        .changed      (changed_a)
    );

    switch_debouncer #(.WIDTH(16), .TICK_DIV(1), .STABLE_TICKS(1)) dut_b (
        .clock        (clock),
        .reset        (reset_b),
        .raw_switches (raw_b),
        .ack          (ack_b),
        .switches     (switches_b),
        .change_pulse (pulse_b),
        .changed      (changed_b)
    );

    always @(negedge clock) begin
        if (pulse_a === 1'b1) begin
            pulse_cnt_a++;
        end
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", tag, got, exp, edge_n);
        end else begin
            $display("ok   %s: %h (edge %0d)", tag, got, edge_n);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            edge_n++;
        end
    endtask

    task automatic step_to(input int k);
        step(k - edge_n);
    endtask

    task automatic check_a(input string tag, input logic [15:0] sw, input logic p, input logic c);
        check_vec({tag, ".switches"}, {16'h0, switches_a}, {16'h0, sw});
        check_vec({tag, ".pulse"}, {31'h0, pulse_a}, {31'h0, p});
        check_vec({tag, ".changed"}, {31'h0, changed_a}, {31'h0, c});
    endtask

    initial begin
        reset_a = 1'b1; raw_a = 16'h0; ack_a = 1'b0;
        reset_b = 1'b1; raw_b = 16'h0; ack_b = 1'b0;
        step(3);
        check_a("reset", 16'h0, 1'b0, 1'b0);

        // Clean edge: s2 changes at edge 2, commits on third tick (edge 12)
        reset_a = 1'b0; edge_n = 0; raw_a = 16'h00A5;
        step_to(1);
        check_a("t1_first_cycle", 16'h0, 1'b0, 1'b0);
        step_to(11);
        check_a("t1_before", 16'h0, 1'b0, 1'b0);
        step_to(12);
        check_a("t1_update", 16'h00A5, 1'b1, 1'b1);
        step_to(13);
        check_a("t1_after", 16'h00A5, 1'b0, 1'b1);
        ack_a = 1'b1;
        // Glitch: bit 3 visible at s2 for ticks 16 and 20 only
        raw_a = 16'h00AD;
        pulse_mark = pulse_cnt_a;
        step_to(14);
        ack_a = 1'b0;
        check_vec("t1_ack_clears", {31'h0, changed_a}, 32'h0);
        step_to(20);
        raw_a = 16'h00A5;
        step_to(24);
        raw_a = 16'h00AD;
        check_vec("t2_glitch_sw", {16'h0, switches_a}, 32'h00A5);
        check_vec("t2_glitch_no_pulse", pulse_cnt_a, pulse_mark);
        check_vec("t2_glitch_no_changed", {31'h0, changed_a}, 32'h0);
        // Held: s2 high at edge 26, ticks 28, 32, commit 36
        step_to(35);
        check_a("t2_held_before", 16'h00A5, 1'b0, 1'b0);
        step_to(36);
        check_a("t2_held_update", 16'h00AD, 1'b1, 1'b1);

        // Independent bits from a fresh reset
        #2 reset_a = 1'b1;
        #1 check_a("t3_reset", 16'h0, 1'b0, 1'b0);
        step(2);
        reset_a = 1'b0; edge_n = 0; raw_a = 16'h0001;
        pulse_mark = pulse_cnt_a;
        step_to(4);
        raw_a = 16'h8001;
        step_to(11);
        check_a("t3_before_b0", 16'h0, 1'b0, 1'b0);
        step_to(12);
        check_a("t3_b0_update", 16'h0001, 1'b1, 1'b1);
        ack_a = 1'b1;
        step_to(13);
        ack_a = 1'b0;
        check_a("t3_b0_acked", 16'h0001, 1'b0, 1'b0);
        step_to(15);
        check_a("t3_before_b15", 16'h0001, 1'b0, 1'b0);
        // Ack collides with the bit-15 update on edge 16
        ack_a = 1'b1;
        step_to(16);
        check_a("t4_collision", 16'h8001, 1'b1, 1'b1);
        step_to(17);
        ack_a = 1'b0;
        check_a("t4_ack_alone", 16'h8001, 1'b0, 1'b0);
        check_vec("t3_pulse_count", pulse_cnt_a - pulse_mark, 32'd2);
        step_to(24);
        check_vec("t4_stays_clear", {31'h0, changed_a}, 32'h0);

        // Reset mid-count: s2 all-ones at 26, ticks 28, 32; reset before 36
        raw_a = 16'hFFFF;
        step_to(33);
        check_vec("t5_pre_reset", {16'h0, switches_a}, 32'h8001);
        reset_a = 1'b1;
        #1 check_a("t5_async_reset", 16'h0, 1'b0, 1'b0);
        step(2);
        reset_a = 1'b0; edge_n = 0;
        step_to(1);
        check_a("t5_first_cycle", 16'h0, 1'b0, 1'b0);
        step_to(11);
        check_a("t5_before", 16'h0, 1'b0, 1'b0);
        step_to(12);
        check_a("t5_update", 16'hFFFF, 1'b1, 1'b1);

        // TICK_DIV=1, STABLE_TICKS=1: raw edge visible three edges later
        reset_b = 1'b0;
        step(2);
        check_vec("t6_idle", {16'h0, switches_b}, 32'h0);
        raw_b = 16'h1234;
        step(2);
        check_vec("t6_edge2_sw", {16'h0, switches_b}, 32'h0);
        check_vec("t6_edge2_pulse", {31'h0, pulse_b}, 32'h0);
        step(1);
        check_vec("t6_edge3_sw", {16'h0, switches_b}, 32'h1234);
        check_vec("t6_edge3_pulse", {31'h0, pulse_b}, 32'h1);
        check_vec("t6_edge3_changed", {31'h0, changed_b}, 32'h1);
        raw_b = 16'h1200;
        step(1);
        check_vec("t6_edge4_pulse", {31'h0, pulse_b}, 32'h0);
        step(1);
        check_vec("t6_second_edge2", {16'h0, switches_b}, 32'h1234);
        step(1);
        check_vec("t6_second_edge3", {16'h0, switches_b}, 32'h1200);
        check_vec("t6_second_pulse", {31'h0, pulse_b}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
